// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants and window decode helper shared by the timing and pixel blocks.
package vga_timing_pkg;
  localparam int CLK_DIV = 4;
  localparam int H_TOTAL = 800;
  localparam int H_SYNC = 96;
  localparam int H_VISIBLE_START = 144;
  localparam int H_VISIBLE_END = 784;
  localparam int V_TOTAL = 525;
  localparam int V_SYNC = 2;
  localparam int V_VISIBLE_START = 35;
  localparam int V_VISIBLE_END = 515;
  localparam int RGB_W = 12;
  typedef logic [9:0] coord_t;
  typedef logic [RGB_W-1:0] rgb_t;
  function automatic logic in_span(coord_t x, coord_t lo, coord_t hi);
    return x >= lo && x < hi;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to pixel-colour consumers.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;
  logic pix_en;
  coord_t hCount;
  coord_t vCount;
  logic bright;
  logic hSync;
  logic vSync;
  logic frame_tick;
  logic [7:0] frame_count;
  modport master(output pix_en, hCount, vCount, bright, hSync, vSync, frame_tick, frame_count);
  modport slave(input pix_en, hCount, vCount, bright, hSync, vSync, frame_tick, frame_count);
endinterface

// File: rtl/vga_pix_div.sv
// vga_pix_div: registered one-clock pixel enable every CLK_DIV system clocks.
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic last;
  assign last = div == DW'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div <= '0;
      pix_en <= 1'b0;
    end else begin
      div <= last ? '0 : div + 1'b1;
      pix_en <= last;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with sync/bright decode registered from next position, plus frame tick.
module vga_timing_gen #(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_VISIBLE_START = vga_timing_pkg::H_VISIBLE_START,
  parameter int H_VISIBLE_END = vga_timing_pkg::H_VISIBLE_END,
  parameter int V_TOTAL = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_VISIBLE_START = vga_timing_pkg::V_VISIBLE_START,
  parameter int V_VISIBLE_END = vga_timing_pkg::V_VISIBLE_END
) (
  input  logic clk,
  input  logic rst,
  vga_timing_gen_if.master vga
);
  import vga_timing_pkg::*;
  logic pix_en;
  logic h_wrap;
  logic tick_next;
  coord_t h_next;
  coord_t v_next;
  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst(rst), .pix_en(pix_en));
  assign vga.pix_en = pix_en;
  always_comb begin
    h_wrap = vga.hCount == coord_t'(H_TOTAL - 1);
    h_next = pix_en ? (h_wrap ? '0 : vga.hCount + 1'b1) : vga.hCount;
    v_next = pix_en && h_wrap ? (vga.vCount == coord_t'(V_TOTAL - 1) ? '0 : vga.vCount + 1'b1) : vga.vCount;
    tick_next = pix_en && h_next == '0 && v_next == coord_t'(V_VISIBLE_END);
  end
  // decode from next position so outputs never lag the counters they describe
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vga.hCount <= '0;
      vga.vCount <= '0;
      vga.hSync <= 1'b0;
      vga.vSync <= 1'b0;
      vga.bright <= 1'b0;
      vga.frame_tick <= 1'b0;
      vga.frame_count <= '0;
    end else begin
      vga.hCount <= h_next;
      vga.vCount <= v_next;
      vga.hSync <= h_next >= coord_t'(H_SYNC);
      vga.vSync <= v_next >= coord_t'(V_SYNC);
      vga.bright <= in_span(h_next, coord_t'(H_VISIBLE_START), coord_t'(H_VISIBLE_END))
                 && in_span(v_next, coord_t'(V_VISIBLE_START), coord_t'(V_VISIBLE_END));
      vga.frame_tick <= tick_next;
      vga.frame_count <= vga.frame_count + 8'(tick_next);
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing that the game's pixel-colour blocks consume: hCount, vCount, bright, plus active-low hSync/vSync to the monitor.
- Divides the 100 MHz system clock to a 25 MHz pixel-enable and runs 640x480@60 counters.
- Emits a one-cycle frame_tick at the start of vertical blanking, so slow game logic can update object positions off-screen.

Parameters:
- CLK_DIV, 4, system clocks per pixel; legal values are 1 and above.
- H_TOTAL, 800, pixels per line.
- H_SYNC, 96, hSync low width, starting at hCount 0.
- H_VISIBLE_START, 144, first visible hCount.
- H_VISIBLE_END, 784, first non-visible hCount after the active region.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width, starting at vCount 0.
- V_VISIBLE_START, 35, first visible vCount.
- V_VISIBLE_END, 515, first non-visible vCount after the active region.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- pix_en  out  1  one-clk pulse, once per CLK_DIV clocks; counters advance on it.
- hCount  out  10  horizontal position, range 0..H_TOTAL-1.
- vCount  out  10  vertical position, range 0..V_TOTAL-1.
- bright  out  1  high inside the visible window.
- hSync  out  1  active-low horizontal sync.
- vSync  out  1  active-low vertical sync.
- frame_tick  out  1  one-clk pulse at the start of vertical blanking.
- frame_count  out  8  frames completed, wraps 255 to 0.

Behaviour:
- Reset (rst=0, async): div=0, hCount=0, vCount=0, pix_en=0, frame_tick=0, frame_count=0, hSync=0, vSync=0, bright=0. The sync values are the decode of position (0,0). Outputs hold these values until the first pix_en after rst rises.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en is registered and high in the cycle after div==CLK_DIV-1. With CLK_DIV=1, pix_en is high every cycle after reset release.
- Counter advance:
  - On a clock edge where pix_en is high: hCount goes to hCount+1, or to 0 when hCount==H_TOTAL-1.
  - On that same wrap, vCount goes to vCount+1, or to 0 when vCount==V_TOTAL-1.
  - Otherwise the counters hold.
- Decode is registered and coherent: bright/hSync/vSync are computed from the next counter values, so each always describes the hCount/vCount visible in the same cycle. There is no skew.
  - hSync = !(hCount < H_SYNC).
  - vSync = !(vCount < V_SYNC).
  - bright = (H_VISIBLE_START <= hCount < H_VISIBLE_END) && (V_VISIBLE_START <= vCount < V_VISIBLE_END).
- frame_tick is high for exactly one clk, in the first cycle where (hCount,vCount) == (0,V_VISIBLE_END). frame_count increments in that same cycle.
- Wrap-around:
  - (799,524) goes to (0,0). No frame_tick is generated there.
  - frame_count at 255 goes to 0.
- Reset asserted mid-line or mid-frame: immediate return to the reset state. No partial pulse may remain on frame_tick or pix_en.
- Width rules: all comparisons are unsigned 10-bit. Parameters must satisfy H_TOTAL<=1024 and V_TOTAL<=1024.
- Frame period at defaults: 800*525*4 = 1,680,000 clk.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480 constants above, including H_VISIBLE_START=144 and V_VISIBLE_START=35, which pixel blocks also use;
  - the RGB width of 12.
- Sub-module vga_pix_div (parameter CLK_DIV; ports clk, rst, pix_en) holds the divider. The counters and decode stay in the top module.

Test Plan:
- Reset release with default parameters -> pix_en first high 4 clks after the first post-reset edge, then every 4 clks; hCount=1 after the first pix_en.
- Run one line -> hSync low for hCount 0..95 and high for 96..799; hCount 799 goes to 0 with vCount incrementing 0 to 1, in the same cycle.
- Run one full frame -> bright high for exactly 640*480 = 307,200 pix_en cycles; vSync low for exactly 1600 pix_en cycles (vCount 0..1).
- Watch frame_tick -> a single 1-clk pulse per 1,680,000 clks, coincident with (0,515); frame_count steps 0 to 1 to 2 over two frames.
- Hold for 256 frames, with CLK_DIV overridden to 1 for speed -> frame_count wraps 255 to 0; no frame_tick at (0,0).
- Assert rst at (400,200) mid-pixel-period -> all outputs are at reset values in the same cycle; after release, timing restarts from (0,0) with the full 4-clk divider period.
